// File: rtl/dcache_sram_ctrl.sv
// dcache_sram_ctrl: sequences the 512x32 byte-enabled data-cache SRAM.
// The single write port is shared between line refills and CPU stores.
// The read port serves the CPU only. During a refill, a read stalls if it
// targets a word of the refill line that has not been written yet.
// Optional feature macro: DCACHE_WR_BUF_EN. It adds a one-entry write buffer
// so that a CPU store to another line can complete while a refill runs.
module dcache_sram_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int LINE_LOG2 = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic [BE_W-1:0]             cpu_be,
  output logic                        cpu_ready,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        fill_start,
  input  logic [ADDR_W-LINE_LOG2-1:0] fill_line,
  input  logic                        fill_valid,
  input  logic [DATA_W-1:0]           fill_data,
  output logic                        fill_ready,
  output logic                        fill_busy,
  output logic                        fill_done,
  output logic                        sram_wr_en,
  output logic [ADDR_W-1:0]           sram_wr_addr,
  output logic [DATA_W-1:0]           sram_wr_data,
  output logic [BE_W-1:0]             sram_wr_byte_en,
  output logic [ADDR_W-1:0]           sram_rd_addr,
  input  logic [DATA_W-1:0]           sram_rd_data
);
  localparam int LINE_W = ADDR_W - LINE_LOG2;
  localparam logic [LINE_LOG2-1:0] LAST_BEAT = '1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [LINE_LOG2-1:0]  cnt_reg, cnt_next;
  logic [LINE_W-1:0]     line_reg, line_next;
  logic                  done_next, fill_done_reg;

  logic                  rvalid_reg;
  logic [DATA_W-1:0]     rdata_hold_reg;
  logic                  snap_hit_reg;
  logic [DATA_W-1:0]     snap_data_reg;
  logic [BE_W-1:0]       snap_be_reg;

  logic                  buf_valid_reg;
  logic [ADDR_W-1:0]     buf_addr_reg;
  logic [DATA_W-1:0]     buf_data_reg;
  logic [BE_W-1:0]       buf_be_reg;

  logic                  beat, drain, accept, wr_direct, wr_ok, same_line, rd_stall;
  logic [DATA_W-1:0]     merged;

  assign beat      = (state_reg == FILL) && fill_valid;
  assign drain     = buf_valid_reg && !beat;
  assign same_line = (cpu_addr[ADDR_W-1:LINE_LOG2] == line_reg);
  // Words at or above the beat counter are not yet written, including the one written this cycle.
  assign rd_stall  = (state_reg == FILL) && same_line && (cpu_addr[LINE_LOG2-1:0] >= cnt_reg);
  assign accept    = cpu_req && cpu_ready;
  assign wr_direct = accept && cpu_we && (state_reg == IDLE);

`ifdef DCACHE_WR_BUF_EN
  logic buf_capture;
  assign wr_ok       = !buf_valid_reg && ((state_reg == IDLE) || !same_line);
  assign buf_capture = accept && cpu_we && (state_reg == FILL);

  // One-entry write buffer: captured during a refill, cleared on its drain cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
      buf_be_reg    <= '0;
    end else if (buf_capture) begin
      buf_valid_reg <= 1'b1;
      buf_addr_reg  <= cpu_addr;
      buf_data_reg  <= cpu_wdata;
      buf_be_reg    <= cpu_be;
    end else if (drain) begin
      buf_valid_reg <= 1'b0;
    end
  end
`else
  assign wr_ok         = (state_reg == IDLE);
  assign buf_valid_reg = 1'b0;
  assign buf_addr_reg  = '0;
  assign buf_data_reg  = '0;
  assign buf_be_reg    = '0;
`endif

  // FSM state register plus refill counter, line latch and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      line_reg      <= '0;
      fill_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      line_reg      <= line_next;
      fill_done_reg <= done_next;
    end
  end

  // Next-state logic: start on fill_start, finish on the last accepted beat.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    line_next  = line_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fill_start) begin
          state_next = FILL;
          line_next  = fill_line;
          cnt_next   = '0;
        end
      end
      FILL: begin
        if (fill_valid) begin
          cnt_next = cnt_reg + LINE_LOG2'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: handshakes and write-port arbitration (refill > buffer drain > CPU store).
  always_comb begin
    fill_busy       = (state_reg == FILL);
    fill_ready      = (state_reg == FILL);
    fill_done       = fill_done_reg;
    cpu_ready       = cpu_we ? wr_ok : !rd_stall;
    sram_rd_addr    = cpu_addr;
    sram_wr_en      = 1'b0;
    sram_wr_addr    = cpu_addr;
    sram_wr_data    = cpu_wdata;
    sram_wr_byte_en = cpu_be;
    if (beat) begin
      sram_wr_en      = 1'b1;
      sram_wr_addr    = {line_reg, cnt_reg};
      sram_wr_data    = fill_data;
      sram_wr_byte_en = {BE_W{1'b1}};
    end else if (drain) begin
      sram_wr_en      = 1'b1;
      sram_wr_addr    = buf_addr_reg;
      sram_wr_data    = buf_data_reg;
      sram_wr_byte_en = buf_be_reg;
    end else if (wr_direct) begin
      sram_wr_en      = 1'b1;
    end
  end

  // Read return: valid one cycle after acceptance; snapshot of any buffered store to the same word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_reg     <= 1'b0;
      rdata_hold_reg <= '0;
      snap_hit_reg   <= 1'b0;
      snap_data_reg  <= '0;
      snap_be_reg    <= '0;
    end else begin
      rvalid_reg <= accept && !cpu_we;
      if (rvalid_reg) begin
        rdata_hold_reg <= merged;
      end
      if (accept && !cpu_we) begin
        snap_hit_reg  <= buf_valid_reg && (buf_addr_reg == cpu_addr);
        snap_data_reg <= buf_data_reg;
        snap_be_reg   <= buf_be_reg;
      end
    end
  end

  // Buffered bytes override the SRAM word so a read never sees a store still in flight.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = (snap_hit_reg && snap_be_reg[gi]) ? snap_data_reg[gi*8 +: 8]
                                                                   : sram_rd_data[gi*8 +: 8];
    end
  endgenerate

  assign cpu_rvalid = rvalid_reg;
  assign cpu_rdata  = rvalid_reg ? merged : rdata_hold_reg;

endmodule

// File: tb/tb_dcache_sram_ctrl.sv
// tb_dcache_sram_ctrl: directed test of dcache_sram_ctrl with a behavioural
// 512x32 byte-enabled SRAM model (read address registered, output combinational).
// When DCACHE_WR_BUF_EN is defined, the write-buffer scenario is also run.
module tb_dcache_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        fill_start;
  logic [5:0]  fill_line;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        fill_ready, fill_busy, fill_done;
  logic        sram_wr_en;
  logic [8:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_byte_en;
  logic [8:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;

  logic [31:0] mem [512];
  logic [8:0]  rd_addr_q;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_sram_ctrl #(.ADDR_W(9), .DATA_W(32), .BE_W(4), .LINE_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_line(fill_line), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_ready(fill_ready), .fill_busy(fill_busy),
    .fill_done(fill_done), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .sram_wr_byte_en(sram_wr_byte_en),
    .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
  );

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // SRAM model
  initial for (int i = 0; i < 512; i++) mem[i] <= '0;
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_wr_addr] <= be_merge(mem[sram_wr_addr], sram_wr_data, sram_wr_byte_en);
    rd_addr_q <= sram_rd_addr;
  end
  assign sram_rd_data = mem[rd_addr_q];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_idle();
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    fill_start = 1'b0;
    fill_valid = 1'b0;
  endtask

  task automatic cpu_rd(input logic [8:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    $display("cpu read  addr=%03h", a);
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    $display("cpu write addr=%03h data=%08h be=%b", a, d, be);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beat_n;
    rst_n = 1'b0;
    set_idle();
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; fill_line = '0; fill_data = '0;
    next(); next();

    // Reset state
    sample();
    check_eq("rst_rvalid", cpu_rvalid, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_eq("rst_busy", fill_busy, 0);
    check_eq("rst_done", fill_done, 0);
    check_eq("rst_fready", fill_ready, 0);
    check_eq("rst_wr_en", sram_wr_en, 0);
    next();
    rst_n = 1'b1;
    next();

    // CPU write then read back in IDLE
    cpu_wr(9'h010, 32'hDEADBEEF, 4'b0011);
    sample();
    check_eq("wr_ready", cpu_ready, 1);
    check_eq("wr_en", sram_wr_en, 1);
    check_eq("wr_addr", sram_wr_addr, 9'h010);
    check_eq("wr_be", sram_wr_byte_en, 4'b0011);
    check_eq("wr_data", sram_wr_data, 32'hDEADBEEF);
    next();
    cpu_rd(9'h010);
    sample();
    check_eq("rd_ready", cpu_ready, 1);
    check_eq("rd_addr", sram_rd_addr, 9'h010);
    check_eq("rd_rvalid_early", cpu_rvalid, 0);
    next();
    set_idle();
    sample();
    check_eq("rd_rvalid", cpu_rvalid, 1);
    check_eq("rd_low16", cpu_rdata[15:0], 16'hBEEF);
    check_eq("rd_word", cpu_rdata, 32'h0000BEEF);
    next();
    sample();
    check_eq("rd_rvalid_off", cpu_rvalid, 0);
    check_eq("rd_hold", cpu_rdata, 32'h0000BEEF);
    next();

    // Refill line 0x05 with continuous beats, reads stalling on unwritten words
    fill_start = 1'b1; fill_line = 6'h05;
    $display("fill start line=05");
    sample();
    check_eq("f5_busy_pre", fill_busy, 0);
    next();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'h100 + k;
      cpu_req = 1'b0; cpu_we = 1'b0;
      if (k >= 2 && k <= 4) cpu_rd(9'h02B);
      if (k == 5) cpu_rd(9'h02A);
      if (k == 6) cpu_rd(9'h02F);
      if (k == 7) cpu_rd(9'h010);
      $display("fill beat %0d data=%08h", k, fill_data);
      sample();
      check_eq($sformatf("f5_fready_%0d", k), fill_ready, 1);
      check_eq($sformatf("f5_busy_%0d", k), fill_busy, 1);
      check_eq($sformatf("f5_wr_en_%0d", k), sram_wr_en, 1);
      check_eq($sformatf("f5_wr_addr_%0d", k), sram_wr_addr, 9'h028 + k);
      check_eq($sformatf("f5_wr_data_%0d", k), sram_wr_data, 32'h100 + k);
      check_eq($sformatf("f5_wr_be_%0d", k), sram_wr_byte_en, 4'hF);
      check_eq($sformatf("f5_done_%0d", k), fill_done, 0);
      case (k)
        2, 3: check_eq($sformatf("f5_stall_2b_%0d", k), cpu_ready, 0);
        4: begin
          check_eq("f5_accept_2b", cpu_ready, 1);
          check_eq("f5_no_rvalid", cpu_rvalid, 0);
        end
        5: begin
          check_eq("f5_accept_2a", cpu_ready, 1);
          check_eq("f5_rvalid_2b", cpu_rvalid, 1);
          check_eq("f5_rdata_2b", cpu_rdata, 32'h103);
        end
        6: begin
          check_eq("f5_stall_2f", cpu_ready, 0);
          check_eq("f5_rvalid_2a", cpu_rvalid, 1);
          check_eq("f5_rdata_2a", cpu_rdata, 32'h102);
        end
        7: begin
          check_eq("f5_other_line", cpu_ready, 1);
          check_eq("f5_stalled_no_rvalid", cpu_rvalid, 0);
        end
        default: ;
      endcase
      next();
    end
    set_idle();
    sample();
    check_eq("f5_done", fill_done, 1);
    check_eq("f5_busy_end", fill_busy, 0);
    check_eq("f5_fready_end", fill_ready, 0);
    check_eq("f5_wr_en_end", sram_wr_en, 0);
    check_eq("f5_rvalid_010", cpu_rvalid, 1);
    check_eq("f5_rdata_010", cpu_rdata, 32'h0000BEEF);
    next();
    sample();
    check_eq("f5_done_off", fill_done, 0);
    next();

    // Refill line 0x02 with alternate-cycle beats; CPU write shares the start cycle
    fill_start = 1'b1; fill_line = 6'h02;
    cpu_wr(9'h1F0, 32'hCAFEF00D, 4'hF);
    sample();
    check_eq("f2_start_wr_ready", cpu_ready, 1);
    check_eq("f2_start_wr_en", sram_wr_en, 1);
    check_eq("f2_start_wr_addr", sram_wr_addr, 9'h1F0);
    next();
    set_idle();
    beat_n = 0;
    for (int c = 0; c < 15; c++) begin
      fill_valid = (c % 2 == 0);
      fill_data  = 32'h200 + beat_n;
`ifndef DCACHE_WR_BUF_EN
      if (c == 1) cpu_wr(9'h1F1, 32'h12345678, 4'hF);
`endif
      sample();
      check_eq($sformatf("f2_wr_en_c%0d", c), sram_wr_en, fill_valid);
      if (fill_valid) begin
        check_eq($sformatf("f2_wr_addr_b%0d", beat_n), sram_wr_addr, 9'h010 + beat_n);
        check_eq($sformatf("f2_wr_data_b%0d", beat_n), sram_wr_data, 32'h200 + beat_n);
        beat_n++;
      end
      check_eq($sformatf("f2_done_c%0d", c), fill_done, 0);
      check_eq($sformatf("f2_busy_c%0d", c), fill_busy, 1);
`ifndef DCACHE_WR_BUF_EN
      if (c == 1) check_eq("f2_wr_stall", cpu_ready, 0);
`endif
      next();
      set_idle();
    end
    sample();
    check_eq("f2_done", fill_done, 1);
    check_eq("f2_busy_end", fill_busy, 0);
    next();
    cpu_rd(9'h013);
    sample();
    check_eq("f2_done_off", fill_done, 0);
    next();
    set_idle();
    sample();
    check_eq("f2_rd_013", cpu_rdata, 32'h203);
    cpu_rd(9'h1F0);
    next();
    set_idle();
    sample();
    check_eq("f2_rd_1f0", cpu_rdata, 32'hCAFEF00D);
    next();

    // Reset in the middle of a refill of line 0x07, then restart
    fill_start = 1'b1; fill_line = 6'h07;
    next();
    fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = 32'h300 + k;
      next();
    end
    fill_valid = 1'b0;
    rst_n = 1'b0;
    $display("reset during fill");
    next();
    rst_n = 1'b1;
    sample();
    check_eq("rf_busy", fill_busy, 0);
    check_eq("rf_done", fill_done, 0);
    check_eq("rf_fready", fill_ready, 0);
    next();
    sample();
    check_eq("rf_done2", fill_done, 0);
    fill_start = 1'b1; fill_line = 6'h07;
    next();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'h400 + k;
      if (k == 2) begin
        fill_start = 1'b1; fill_line = 6'h0A;
      end
      sample();
      check_eq($sformatf("rf_wr_addr_%0d", k), sram_wr_addr, 9'h038 + k);
      next();
      fill_start = 1'b0;
    end
    fill_valid = 1'b0;
    sample();
    check_eq("rf_fill_done", fill_done, 1);
    next();

`ifdef DCACHE_WR_BUF_EN
    // Write buffer: store during refill, merged read before drain, drain in first gap
    cpu_wr(9'h100, 32'hAABBCCDD, 4'hF);
    next();
    set_idle();
    fill_start = 1'b1; fill_line = 6'h09;
    next();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'h500 + k;
      cpu_req = 1'b0; cpu_we = 1'b0;
      if (k == 1) cpu_wr(9'h100, 32'h11223344, 4'b1000);
      if (k == 2) cpu_rd(9'h100);
      if (k == 3) cpu_wr(9'h101, 32'h55667788, 4'hF);
      sample();
      check_eq($sformatf("wb_wr_addr_%0d", k), sram_wr_addr, 9'h048 + k);
      check_eq($sformatf("wb_wr_be_%0d", k), sram_wr_byte_en, 4'hF);
      if (k == 1) check_eq("wb_accept", cpu_ready, 1);
      if (k == 2) check_eq("wb_rd_accept", cpu_ready, 1);
      if (k == 3) begin
        check_eq("wb_full_stall", cpu_ready, 0);
        check_eq("wb_rvalid", cpu_rvalid, 1);
        check_eq("wb_merged", cpu_rdata, 32'h11BBCCDD);
      end
      next();
    end
    set_idle();
    sample();
    check_eq("wb_drain_en", sram_wr_en, 1);
    check_eq("wb_drain_addr", sram_wr_addr, 9'h100);
    check_eq("wb_drain_be", sram_wr_byte_en, 4'b1000);
    check_eq("wb_drain_data", sram_wr_data, 32'h11223344);
    next();
    cpu_rd(9'h100);
    sample();
    check_eq("wb_after_drain_en", sram_wr_en, 0);
    next();
    set_idle();
    sample();
    check_eq("wb_sram_word", cpu_rdata, 32'h11BBCCDD);
    next();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_sram_ctrl.md
Name: dcache_sram_ctrl

Overview:
- Sequences the data-cache simple-dual-port SRAM: 512 x 32, byte-enabled, unregistered output, so read data is valid 1 cycle after the address is clocked in.
- Shares the single SRAM write port between the CPU load/store port and the line-refill engine. Shares the read port with the CPU only.
- Refill bursts write one full cache line. While a refill runs, CPU accesses that would hit unwritten refill words stall.
- Sits between the dcache tag/hit logic and the SRAM wrapper instance.

Parameters:
- ADDR_W, 9, SRAM word address width.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- LINE_LOG2, 3, log2 of words per line (8 words).

Ports:
- clk  in  1  single clock for all logic and the SRAM (drives both wr_clk and rd_clk).
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  BE_W  write byte enables.
- cpu_ready  out  1  request accepted this cycle when cpu_req && cpu_ready.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  DATA_W  read data.
- fill_start  in  1  begin a line refill.
- fill_line  in  ADDR_W-LINE_LOG2  line index to refill.
- fill_valid  in  1  refill beat valid.
- fill_data  in  DATA_W  refill beat data.
- fill_ready  out  1  refill beat accepted when fill_valid && fill_ready.
- fill_busy  out  1  refill in progress.
- fill_done  out  1  one-cycle pulse, line complete.
- sram_wr_en  out  1  SRAM write enable.
- sram_wr_addr  out  ADDR_W  SRAM write address.
- sram_wr_data  out  DATA_W  SRAM write data.
- sram_wr_byte_en  out  BE_W  SRAM write byte enables.
- sram_rd_addr  out  ADDR_W  SRAM read address.
- sram_rd_data  in  DATA_W  SRAM read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE, beat counter 0, line latch 0.
  - cpu_rvalid=0, cpu_rdata=0, fill_busy=0, fill_done=0, fill_ready=0, sram_wr_en=0.
  - Reset mid-refill abandons the burst; fill_done is not pulsed. Already-written words stay in the SRAM.
- FSM has two states.
  - IDLE -> FILL on fill_start. fill_line is latched and the counter cleared.
  - fill_start while in FILL is ignored.
  - FILL -> IDLE on the edge that accepts the beat with counter == 2^LINE_LOG2-1. fill_done=1 in the following cycle only, in which fill_busy=0.
- fill_busy = (state==FILL). fill_ready = (state==FILL), unconditionally.
- Refill beat write: sram_wr_en=1, addr={line latch, counter}, byte_en all ones, data=fill_data. The counter increments per accepted beat and wraps to 0 after the last beat.
- Write-port priority: refill beat > write-buffer drain (optional feature) > CPU write.
- CPU write in IDLE: cpu_ready=1 and the write goes straight to the SRAM port in the same cycle (addr/data/be are combinational pass-through).
- CPU write in FILL: cpu_ready=0 (without the optional feature).
- CPU read: sram_rd_addr=cpu_addr (combinational). cpu_rvalid=1 in cycle N+1 for a read accepted in cycle N, and cpu_rdata=sram_rd_data in that cycle. cpu_rvalid is 0 otherwise; cpu_rdata holds its last value.
- Read stall in FILL: cpu_ready=0 for a read when cpu_addr[ADDR_W-1:LINE_LOG2]==line latch and cpu_addr[LINE_LOG2-1:0] >= counter. This covers the word being written this cycle, so read/write collisions never occur. Reads to other lines proceed at full rate.
- fill_start and a CPU write in the same IDLE cycle: the CPU write is accepted and FILL starts the next cycle.
- fill_valid outside FILL is ignored.

Optional Feature:
- Macro DCACHE_WR_BUF_EN.
- When defined, adds a one-entry write buffer (addr, data, be, valid).
  - A CPU write in FILL that targets another line is captured in the buffer with cpu_ready=1, provided the buffer is empty.
  - The buffer drains to the SRAM in the first cycle with no refill beat (fill_valid low, or IDLE).
  - A new CPU write while the buffer is valid stalls, including in IDLE during the drain cycle.
  - A CPU write targeting the fill line still stalls.
  - Read of the buffered address: a snapshot of the buffer is registered at acceptance, and cpu_rdata merges the buffered bytes (where be=1) over sram_rd_data. This also applies when the drain occurs in the same cycle.
  - Reset clears buffer valid.
- When not defined: no buffer; every CPU write in FILL stalls.

Test Plan:
- Reset then idle: all outputs 0. CPU write addr 0x010, data 0xDEADBEEF, be 4'b0011; read 0x010 next cycle -> rvalid 1 cycle later with data whose low 16 bits are 0xBEEF.
- fill_start line 0x05, 8 consecutive beats 0x100..0x107 -> SRAM writes addr 0x028..0x02F, fill_done pulses the cycle after the 8th beat, fill_busy falls in that same cycle.
- During the above fill after 3 beats: read 0x02A -> accepted (rvalid next cycle, data 0x102); read 0x02B -> cpu_ready=0 until the beat for 0x02B has been accepted.
- fill_valid gaps (beats on alternate cycles) -> counter holds across gaps, correct addresses, exactly one fill_done.
- rst_n low after beat 4 of a fill -> IDLE, fill_busy=0, no fill_done; a new fill_start restarts at counter 0.
- With DCACHE_WR_BUF_EN: CPU write to 0x100, data 0x11223344, be 4'b1000, during a fill with continuous beats -> ready=1, no SRAM write until the first gap. A read of 0x100 before the drain returns byte3=0x11 merged over the old SRAM word.
